add_settle_ctrl: RTL and testbench



---
 rtl/add_pkg.sv | 14 +
 rtl/add_settle_ctrl.sv | 135 +++++++++++++
 tb/tb_add_settle_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types and defaults for the adder settle controller
package add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } add_state_e;

    localparam int ADD_WIDTH         = 4;
    localparam int ADD_SETTLE_CYCLES = 3;
    localparam int ADD_CNT_W         = 8;

endpackage

// File: rtl/add_settle_ctrl.sv
// rtl/add_settle_ctrl.sv - holds operands on an external ripple adder, waits, captures the sum
// Optional settle-stability check enabled by macro ADD_SETTLE_CHECK_EN.
module add_settle_ctrl
    import add_pkg::*;
#(
    parameter int WIDTH         = ADD_WIDTH,
    parameter int SETTLE_CYCLES = ADD_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH:0]   add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             settle_err
);

    localparam logic [ADD_CNT_W-1:0] CNT_LOAD = ADD_CNT_W'(SETTLE_CYCLES - 1);

    add_state_e           state_q, state_d;
    logic [ADD_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     add_a_q, add_a_d;
    logic [WIDTH-1:0]     add_b_q, add_b_d;
    logic                 add_cin_q, add_cin_d;
    logic [WIDTH:0]       out_sum_q, out_sum_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 capture_ok;

`ifdef ADD_SETTLE_CHECK_EN
    localparam bit HAS_PRIOR = (SETTLE_CYCLES >= 2);
    logic [WIDTH:0] prev_sum_q, prev_sum_d;
    logic           settle_err_q, settle_err_d;

    // A single-cycle settle window has no earlier sample to compare against.
    assign capture_ok = !HAS_PRIOR || (add_sum == prev_sum_q);
    assign prev_sum_d = (state_q == ST_SETTLE) ? add_sum : prev_sum_q;
    assign settle_err_d = settle_err_q ||
                          ((state_q == ST_SETTLE) && (cnt_q == '0) && !capture_ok);
    assign settle_err = settle_err_q;
`else
    assign capture_ok = 1'b1;
    assign settle_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    add_a_d    = in_a;
                    add_b_d    = in_b;
                    add_cin_d  = in_cin;
                    cnt_d      = CNT_LOAD;
                    in_ready_d = 1'b0;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (capture_ok) begin
                    out_sum_d   = add_sum;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ADD_SETTLE_CHECK_EN
            prev_sum_q   <= '0;
            settle_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef ADD_SETTLE_CHECK_EN
            prev_sum_q   <= prev_sum_d;
            settle_err_q <= settle_err_d;
`endif
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_add_settle_ctrl.sv
// tb/tb_add_settle_ctrl.sv - directed scoreboard bench for add_settle_ctrl
module tb_add_settle_ctrl;

    localparam int W = 4;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_cin;
    logic [W-1:0] add_a, add_b;
    logic         add_cin;
    logic [W:0]   add_sum;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_sum;
    logic         settle_err;

    logic         force_en;
    logic [W:0]   force_val;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W:0]   sb[$];

    always #5 clk = ~clk;

    // Ideal adder standing in for the external ripple adder; force_* injects a glitch.
    assign add_sum = force_en ? force_val
                              : ({1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin});

    add_settle_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .settle_err(settle_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Input handshake, then wait for out_valid; returns edges elapsed since the handshake.
    task automatic send_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                 output int lat);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        check("in_ready_before_op", in_ready, 1);
        tick();
        in_valid = 1'b0;
        sb.push_back(ref_sum(a, b, c));
        check("add_a_driven", add_a, a);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop_compare(input string tag);
        logic [W:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check(tag, out_sum, e);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        int lat;
        out_ready = 1'b1;
        send_and_wait(a, b, c, lat);
        check({tag, "_latency"}, lat, S);
        check({tag, "_valid"}, out_valid, 1);
        pop_compare({tag, "_sum"});
        tick();
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
        check({tag, "_add_a_kept"}, add_a, a);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        out_ready = 1'b1; force_en = 1'b0; force_val = '0;
        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_add_a", add_a, 0);
        check("rst_settle_err", settle_err, 0);
        rst_n = 1'b1;
        tick();

        run_op("op_0_1", 4'b0000, 4'b0001, 1'b0);
        run_op("op_f_1", 4'b1111, 4'b0001, 1'b0);
        run_op("op_f_f_c", 4'b1111, 4'b1111, 1'b1);
        run_op("op_a_5", 4'b1010, 4'b0101, 1'b0);

        // Backpressure: hold for 5 cycles with a competing request that must be ignored.
        out_ready = 1'b0;
        send_and_wait(4'b0110, 4'b0011, 1'b1, lat);
        check("bp_latency", lat, S);
        in_valid = 1'b1; in_a = 4'b1001; in_b = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_held", out_valid, 1);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_add_a_held", add_a, 4'b0110);
        end
        pop_compare("bp_sum");
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);

        // Reset in the middle of SETTLE discards the operation.
        in_a = 4'b0101; in_b = 4'b0101; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_in_ready_low", in_ready, 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_add_a", add_a, 0);
        check("mid_rst_add_b", add_b, 0);
        check("mid_rst_out_sum", out_sum, 0);
        check("mid_rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();
        run_op("post_rst_3_4", 4'b0011, 4'b0100, 1'b0);

        // Glitch on add_sum during the counter=0 cycle.
        out_ready = 1'b1;
        in_a = 4'b0010; in_b = 4'b0001; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        force_val = ref_sum(4'b0010, 4'b0001, 1'b0) ^ 5'b00100;
        force_en = 1'b1;
        sb.push_back(force_val);
        tick();
`ifdef ADD_SETTLE_CHECK_EN
        check("glitch_deferred", out_valid, 0);
        check("glitch_err_set", settle_err, 1);
        tick();
`else
        check("glitch_err_clear", settle_err, 0);
`endif
        check("glitch_valid", out_valid, 1);
        pop_compare("glitch_sum");
        force_en = 1'b0;
        tick();
        check("glitch_idle", in_ready, 1);
`ifdef ADD_SETTLE_CHECK_EN
        check("glitch_err_sticky", settle_err, 1);
`endif

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
